factor_game_ctrl: RTL and testbench
===================================

Name: factor_game_ctrl

Overview:
- Top-level game sequencer for the prime-factorization board game.
- Takes the player switch and key inputs and fetches a target number from the question source. Each DEC press divides the remaining value by the selected prime, with a sequential divider sub-module.
- Tracks lives and score, and exposes the remaining value, lives, score and state to the HEX display path and LEDR.
- Sits between the board I/O and the question ROM / 7-seg decoders.

Parameters:
W, 16, width of target / remaining value
SCORE_W, 8, width of score counter (saturating)

Ports:
CLK  in  1  system clock
RST  in  1  reset
READY  in  1  game-enable switch (level)
QUE  in  1  question switch; rising edge requests a new question
DEC  in  1  decide key; rising edge commits the selected prime
CLR  in  1  give-up key; rising edge forfeits the current question
SEL  in  3  prime index 0..7 -> 2,3,5,7,11,13,17,19
HP  in  2  initial lives = HP+1 (1..4)
Q_REQ  out  1  question request to question source
Q_ACK  in  1  question source ack, Q_VAL valid same cycle
Q_VAL  in  W  target number
REM  out  W  remaining (unfactored) value
LIVES  out  3  lives remaining
SCORE  out  SCORE_W  solved-question count
STATE  out  3  FSM state code
BUSY  out  1  divider running
LEDR  out  1  high in SOLVED

Behaviour:
- One clock CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE, REM=0, LIVES=0, SCORE=0, Q_REQ=0, BUSY=0, LEDR=0, all edge-detect history regs=0.
- Inputs are already synchronized upstream.
- Edge detect: X_rise = X & ~X_q. An edge is acted on only in the state that consumes it; otherwise it is dropped.
- State codes: IDLE=0, ARMED=1, FETCH=2, PLAY=3, DIVIDE=4, SOLVED=5, OVER=6.
- IDLE: on READY=1 load LIVES=HP+1 and SCORE=0, then go to ARMED.
- ARMED: on QUE_rise go to FETCH.
- FETCH:
  - Q_REQ=1 until a cycle with Q_ACK=1; on that cycle capture Q_VAL and drop Q_REQ.
  - Q_VAL>=2: REM=Q_VAL, go to PLAY.
  - Q_VAL<2: go to ARMED, REM and SCORE unchanged.
- PLAY:
  - CLR_rise: LIVES-1. If the result is 0 go to OVER, else go to ARMED.
  - Else DEC_rise: latch prime(SEL), go to DIVIDE, pulse div start on the entry cycle.
  - CLR has priority over DEC in the same cycle.
- DIVIDE:
  - BUSY=1. Wait for div done, then update on the cycle after done.
  - remainder==0: REM=quotient. If quotient==1: SCORE+1 (saturate at all-ones), go to SOLVED; else go to PLAY.
  - remainder!=0: REM unchanged, LIVES-1. If the result is 0 go to OVER, else go to PLAY.
  - DEC/CLR edges during DIVIDE are ignored.
- SOLVED: LEDR=1; when QUE=0 go to ARMED.
- OVER: LIVES=0, SCORE held; when READY=0 go to IDLE.
- READY=0 in any non-IDLE state: go to IDLE next cycle. Q_REQ=0, divider aborted, BUSY=0, REM and SCORE held. This overrides all other transitions except RST.
- LIVES never underflows.
- Latency: DEC_rise sampled at cycle t, DIVIDE entered t+1 with start, done at t+1+W, REM/LIVES updated at t+2+W, state back to PLAY/SOLVED/OVER at t+2+W.

Decomposition:
- Shared package factor_game_pkg holds the state enum/codes, the prime lookup constant (8 x 5 bits), and the default W.
- One sub-module, prime_div:
  - Restoring divider, W-bit dividend by 5-bit divisor, one quotient bit per cycle.
  - Interface: start, abort, dividend, divisor -> quotient, remainder, done.
  - done is a 1-cycle pulse exactly W cycles after start.
  - abort returns it to idle.

Test Plan:
- HP=1, READY=1, QUE rise, Q_VAL=12 with Q_ACK -> LIVES=2, REM=12. Then SEL=0 DEC -> REM=6 after W+2 cycles; SEL=0 DEC -> REM=3; SEL=1 DEC -> REM=1, SCORE=1, STATE=5, LEDR=1. QUE=0 -> STATE=1.
- Q_VAL=9, SEL=0 DEC -> REM=9, LIVES 2->1, STATE=3.
- HP=0 (LIVES=1), wrong prime -> LIVES=0, STATE=6. READY=0 -> STATE=0.
- In PLAY, DEC and CLR rise in the same cycle -> no divide started, LIVES-1, STATE=1.
- READY dropped 5 cycles into DIVIDE -> next cycle STATE=0, BUSY=0, REM held. Q_ACK returning Q_VAL=1 -> STATE=1, SCORE unchanged.
- SCORE saturation: force 255 solves with SCORE_W=8 -> SCORE stays 255. Q_ACK delayed 10 cycles -> Q_REQ held high exactly until the ack cycle.

Source files
------------

// File: rtl/factor_game_pkg.sv
// Shared types and constants for the prime-factorization game sequencer.
package factor_game_pkg;

   localparam int unsigned W_DEF   = 16;
   localparam int unsigned PRIME_W = 5;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned LIVES_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_FETCH  = 3'd2,
      ST_PLAY   = 3'd3,
      ST_DIVIDE = 3'd4,
      ST_SOLVED = 3'd5,
      ST_OVER   = 3'd6
   } state_t;

   // Prime table indexed by the player's selector; entry 0 is the rightmost.
   localparam logic [7:0][PRIME_W-1:0] PRIME_LUT = {
      5'd19, 5'd17, 5'd13, 5'd11, 5'd7, 5'd5, 5'd3, 5'd2
   };

   // Map a selector value to its prime.
   function automatic logic [PRIME_W-1:0] prime_of(input logic [SEL_W-1:0] sel);
      return PRIME_LUT[sel];
   endfunction

endpackage

// File: rtl/prime_div.sv
// Restoring divider: W-bit dividend by a small divisor, one quotient bit per cycle.
// done pulses exactly W cycles after start; abort returns it to idle.
module prime_div
   import factor_game_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned DW = PRIME_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  dividend,
   input  logic [DW-1:0] divisor,
   output logic [W-1:0]  quotient,
   output logic [DW-1:0] remainder,
   output logic          done
);

   localparam int unsigned CNT_W = $clog2(W + 1);

   logic [CNT_W-1:0] cnt;
   logic             running;
   logic [DW-1:0]    step_r_in;
   logic [W-1:0]     step_q_in;
   logic [DW:0]      trial;
   logic [DW-1:0]    step_r;
   logic [W-1:0]     step_q;

   // One restoring step; the start cycle seeds the step from the fresh dividend.
   always_comb begin
      step_r_in = start ? '0 : remainder;
      step_q_in = start ? dividend : quotient;
      trial     = {step_r_in, step_q_in[W-1]};
      step_r    = DW'(trial);
      step_q    = {step_q_in[W-2:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
         step_r = DW'(trial - {1'b0, divisor});
         step_q = {step_q_in[W-2:0], 1'b1};
      end
   end

   // Iteration counter, shift registers and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
         end else if (start) begin
            quotient  <= step_q;
            remainder <= step_r;
            cnt       <= CNT_W'(W - 1);
            running   <= 1'b1;
         end else if (running) begin
            quotient  <= step_q;
            remainder <= step_r;
            cnt       <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/factor_game_ctrl.sv
// Top-level game sequencer: fetches a target, divides it down by chosen primes,
// and tracks lives and score for the display path.
module factor_game_ctrl
   import factor_game_pkg::*;
#(
   parameter int unsigned W       = W_DEF,
   parameter int unsigned SCORE_W = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               READY,
   input  logic               QUE,
   input  logic               DEC,
   input  logic               CLR,
   input  logic [SEL_W-1:0]   SEL,
   input  logic [1:0]         HP,
   output logic               Q_REQ,
   input  logic               Q_ACK,
   input  logic [W-1:0]       Q_VAL,
   output logic [W-1:0]       REM,
   output logic [LIVES_W-1:0] LIVES,
   output logic [SCORE_W-1:0] SCORE,
   output logic [2:0]         STATE,
   output logic               BUSY,
   output logic               LEDR
);

   state_t               state, state_n;
   logic                 que_q, dec_q, clr_q;
   logic                 que_rise, dec_rise, clr_rise;
   logic [W-1:0]         rem_n;
   logic [LIVES_W-1:0]   lives_n, lives_dec;
   logic [SCORE_W-1:0]   score_n, score_inc;
   logic [PRIME_W-1:0]   prime_q, prime_n;
   logic                 start_q, start_n;
   logic                 div_abort;
   logic [W-1:0]         div_quo;
   logic [PRIME_W-1:0]   div_rem;
   logic                 div_done;

   assign que_rise  = QUE & ~que_q;
   assign dec_rise  = DEC & ~dec_q;
   assign clr_rise  = CLR & ~clr_q;
   assign lives_dec = (LIVES != '0) ? LIVES - LIVES_W'(1) : '0;
   assign score_inc = (SCORE == '1) ? SCORE : SCORE + SCORE_W'(1);
   assign div_abort = (state == ST_DIVIDE) && !READY;
   assign STATE     = state;

   prime_div #(
      .W  (W),
      .DW (PRIME_W)
   ) u_div (
      .clk       (CLK),
      .rst       (RST),
      .start     (start_q),
      .abort     (div_abort),
      .dividend  (REM),
      .divisor   (prime_q),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Next-state and datapath update; dropping READY overrides everything.
   always_comb begin
      state_n = state;
      rem_n   = REM;
      lives_n = LIVES;
      score_n = SCORE;
      prime_n = prime_q;
      start_n = 1'b0;
      if (state != ST_IDLE && !READY) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (READY) begin
                  lives_n = LIVES_W'(HP) + LIVES_W'(1);
                  score_n = '0;
                  state_n = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (que_rise) state_n = ST_FETCH;
            end
            ST_FETCH: begin
               if (Q_ACK) begin
                  if (Q_VAL >= W'(2)) begin
                     rem_n   = Q_VAL;
                     state_n = ST_PLAY;
                  end else begin
                     state_n = ST_ARMED;
                  end
               end
            end
            ST_PLAY: begin
               if (clr_rise) begin
                  lives_n = lives_dec;
                  state_n = (lives_dec == '0) ? ST_OVER : ST_ARMED;
               end else if (dec_rise) begin
                  prime_n = prime_of(SEL);
                  start_n = 1'b1;
                  state_n = ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               if (div_done) begin
                  if (div_rem == '0) begin
                     rem_n = div_quo;
                     if (div_quo == W'(1)) begin
                        score_n = score_inc;
                        state_n = ST_SOLVED;
                     end else begin
                        state_n = ST_PLAY;
                     end
                  end else begin
                     lives_n = lives_dec;
                     state_n = (lives_dec == '0) ? ST_OVER : ST_PLAY;
                  end
               end
            end
            ST_SOLVED: begin
               if (!QUE) state_n = ST_ARMED;
            end
            ST_OVER: begin
               lives_n = '0;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         que_q   <= 1'b0;
         dec_q   <= 1'b0;
         clr_q   <= 1'b0;
         REM     <= '0;
         LIVES   <= '0;
         SCORE   <= '0;
         prime_q <= '0;
         start_q <= 1'b0;
         Q_REQ   <= 1'b0;
         BUSY    <= 1'b0;
         LEDR    <= 1'b0;
      end else begin
         state   <= state_n;
         que_q   <= QUE;
         dec_q   <= DEC;
         clr_q   <= CLR;
         REM     <= rem_n;
         LIVES   <= lives_n;
         SCORE   <= score_n;
         prime_q <= prime_n;
         start_q <= start_n;
         Q_REQ   <= (state_n == ST_FETCH);
         BUSY    <= (state_n == ST_DIVIDE);
         LEDR    <= (state_n == ST_SOLVED);
      end
   end

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Scoreboard bench for factor_game_ctrl: divide outcomes are predicted by a
// reference model when DEC is pressed and compared when the divide completes.
module tb_factor_game_ctrl;

   localparam int W = 16;

   typedef struct {
      int rem;
      int lives;
      int score;
      int state;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready, que, dec, clr, q_ack;
   logic [2:0]    sel;
   logic [1:0]    hp;
   logic [W-1:0]  q_val;
   logic          q_req, busy, ledr;
   logic [W-1:0]  rem;
   logic [2:0]    lives;
   logic [7:0]    score;
   logic [2:0]    state;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_rem, m_lives, m_score;
   int   primes [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
   exp_t sb_q [$];

   factor_game_ctrl #(.W(W), .SCORE_W(8)) dut (
      .CLK   (clk),
      .RST   (rst),
      .READY (ready),
      .QUE   (que),
      .DEC   (dec),
      .CLR   (clr),
      .SEL   (sel),
      .HP    (hp),
      .Q_REQ (q_req),
      .Q_ACK (q_ack),
      .Q_VAL (q_val),
      .REM   (rem),
      .LIVES (lives),
      .SCORE (score),
      .STATE (state),
      .BUSY  (busy),
      .LEDR  (ledr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_game(input int h);
      hp    = 2'(h);
      ready = 1'b1;
      cyc(1);
      m_lives = h + 1;
      m_score = 0;
      check("start_state", state, 1);
      check("start_lives", lives, m_lives);
      check("start_score", score, 0);
   endtask

   task automatic stop_game();
      ready = 1'b0;
      cyc(1);
      check("stop_state", state, 0);
      check("stop_busy", busy, 0);
   endtask

   task automatic fetch(input int val, input int delay);
      que = 1'b0;
      cyc(1);
      que = 1'b1;
      cyc(1);
      check("fetch_state", state, 2);
      for (int i = 0; i < delay; i++) begin
         check("qreq_wait", q_req, 1);
         cyc(1);
      end
      q_val = W'(val);
      q_ack = 1'b1;
      check("qreq_ack_cycle", q_req, 1);
      cyc(1);
      q_ack = 1'b0;
      if (val >= 2) m_rem = val;
      check("qreq_drop", q_req, 0);
      check("fetch_next_state", state, (val >= 2) ? 3 : 1);
      check("fetch_rem", rem, m_rem);
      check("fetch_score", score, m_score);
   endtask

   task automatic press_dec(input int s);
      exp_t e;
      int   p;
      int   n;
      p = primes[s];
      if (m_rem % p == 0) begin
         m_rem = m_rem / p;
         if (m_rem == 1) begin
            if (m_score < 255) m_score++;
            e.state = 5;
         end else begin
            e.state = 3;
         end
      end else begin
         if (m_lives > 0) m_lives--;
         e.state = (m_lives == 0) ? 6 : 3;
      end
      e.rem   = m_rem;
      e.lives = m_lives;
      e.score = m_score;
      sb_q.push_back(e);

      sel = 3'(s);
      dec = 1'b1;
      cyc(1);
      dec = 1'b0;
      check("div_entry_state", state, 4);
      check("div_busy", busy, 1);
      n = 0;
      while (state == 3'd4 && n < W + 5) begin
         cyc(1);
         n++;
      end
      check("div_latency", n, W + 1);
      e = sb_q.pop_front();
      check("div_rem", rem, e.rem);
      check("div_lives", lives, e.lives);
      check("div_score", score, e.score);
      check("div_state", state, e.state);
      check("div_ledr", ledr, (e.state == 5) ? 1 : 0);
      check("div_busy_done", busy, 0);
   endtask

   initial begin
      rst = 1'b1; ready = 1'b0; que = 1'b0; dec = 1'b0; clr = 1'b0;
      q_ack = 1'b0; q_val = '0; sel = '0; hp = '0;
      m_rem = 0; m_lives = 0; m_score = 0;
      cyc(2);
      check("rst_state", state, 0);
      check("rst_rem", rem, 0);
      check("rst_lives", lives, 0);
      check("rst_score", score, 0);
      check("rst_qreq", q_req, 0);
      check("rst_busy", busy, 0);
      check("rst_ledr", ledr, 0);
      rst = 1'b0;
      cyc(1);

      // Full solve of 12 = 2*2*3, invalid target, wrong prime, delayed ack.
      start_game(1);
      fetch(12, 0);
      press_dec(0);
      press_dec(0);
      press_dec(1);
      que = 1'b0;
      cyc(1);
      check("solved_to_armed", state, 1);
      check("armed_ledr", ledr, 0);
      fetch(1, 0);
      fetch(9, 10);
      press_dec(0);
      press_dec(1);
      press_dec(1);
      stop_game();

      // Single life, wrong prime ends the game; lives never underflow.
      start_game(0);
      fetch(10, 2);
      press_dec(1);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      check("over_lives_floor", lives, 0);
      check("over_state_hold", state, 6);
      stop_game();

      // CLR beats DEC; READY dropped mid-divide aborts it.
      start_game(3);
      fetch(35, 0);
      clr = 1'b1;
      dec = 1'b1;
      cyc(1);
      clr = 1'b0;
      dec = 1'b0;
      m_lives--;
      check("clrdec_state", state, 1);
      check("clrdec_lives", lives, m_lives);
      check("clrdec_busy", busy, 0);
      check("clrdec_rem", rem, 35);
      fetch(35, 0);
      sel = 3'd2;
      dec = 1'b1;
      cyc(1);
      dec = 1'b0;
      check("abort_entry", state, 4);
      cyc(4);
      ready = 1'b0;
      cyc(1);
      check("abort_state", state, 0);
      check("abort_busy", busy, 0);
      check("abort_rem", rem, 35);
      check("abort_lives", lives, m_lives);
      check("abort_qreq", q_req, 0);
      cyc(W);
      check("abort_idle_hold", state, 0);
      check("abort_rem_hold", rem, 35);

      // Score saturation over 256 solves.
      start_game(3);
      for (int i = 0; i < 256; i++) begin
         fetch(2, 0);
         press_dec(0);
      end
      check("score_saturated", score, 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
